tl_response_packetizer: RTL and testbench
=========================================

// Module: tl_response_packetizer
// PURPOSE
//  Successor to the single-buffer TileLink response bridge. Accepts TileLink frames
//  from GenericDeserializer on the controller clock and queues them in a FIFO_DEPTH
//  deep packet FIFO. Packs each frame into a tl_host.py packet with a configurable
//  address width, and streams it byte-by-byte to the UART TX path.
//  Sits between GenericDeserializer and uart_tx. Adds truncation error flags and a packet counter.
// PARAMETERS
//  ADDR_BYTES  4   address bytes per packet: 4 (legacy "<BBBBLQ") or 8 ("<BBBBQQ")
//  FIFO_DEPTH  4   queued packets; power of two, >= 2
//  CNT_W       16  width of tx_pkt_count
//  (derived) PKT_BYTES = 12 + ADDR_BYTES
// PORTS
//  clk                  in   1    controller clock; the only clock
//  reset                in   1    asynchronous, active-high reset
//  tl_out_valid         in   1    deserializer frame valid
//  tl_out_ready         out  1    frame accept; equals !fifo_full
//  tl_out_bits_chanId   in   3    channel id
//  tl_out_bits_opcode   in   3    opcode
//  tl_out_bits_param    in   3    param
//  tl_out_bits_size     in   8    log2 transfer size
//  tl_out_bits_source   in   8    source id (not packed)
//  tl_out_bits_address  in   64   address
//  tl_out_bits_data     in   64   data
//  tl_out_bits_corrupt  in   1    corrupt
//  tl_out_bits_union    in   9    denied/mask
//  tx_valid             out  1    byte valid toward uart_tx
//  tx_ready             in   1    uart_tx byte accept
//  tx_data              out  8    packet byte, byte 0 first
//  status_clear         in   1    sync clear of flags and counter
//  addr_trunc_err       out  1    sticky: accepted address[63:8*ADDR_BYTES] != 0 (never set when ADDR_BYTES=8)
//  union_trunc_err      out  1    sticky: accepted frame had union[8]=1
//  tx_pkt_count         out  CNT_W  packets fully sent; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: all outputs 0 except tl_out_ready=1. FIFO empty, FSM IDLE. A partially sent
//   packet is discarded. The next packet after reset starts at byte 0.
//  Packet layout (byte index): 0 {5'b0,chanId}; 1 {corrupt,param,1'b0,opcode};
//   2 size; 3 union[7:0]; 4..3+ADDR_BYTES address LE; next 8 bytes data LE.
//  Accept: frame packed and pushed on tl_out_valid && tl_out_ready. Unaccepted frames untouched.
//  FSM IDLE: if FIFO non-empty, pop head into shift register, byte_idx=0 -> SEND.
//  FSM SEND: tx_valid=1, tx_data=shreg[7:0], held stable until tx_ready.
//   On handshake: shift by 8 bits, byte_idx++.
//   On handshake of byte PKT_BYTES-1: tx_pkt_count++.
//   Then, if FIFO non-empty, load the next packet in the same cycle (no bubble); else -> IDLE.
//  Latency: accept into an empty FIFO while IDLE -> tx_valid high 2 cycles later.
//  Full: tl_out_ready low while FIFO holds FIFO_DEPTH entries. A pop in a full cycle does
//   not admit a push that cycle (ready is registered off count). Frames are never dropped.
//  Empty: with FIFO empty and SEND done, tx_valid drops the cycle after the last byte.
//  Flags: set on the accepting cycle. status_clear wins over a same-cycle set.
//   Counter clear wins over a same-cycle increment.
//  FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  tl_uart_pkg: CH_A=0..CH_E=4 constants, field widths, pkt_bytes(addr_bytes) function,
//   pack_opcode(corrupt,param,opcode) function. Shared with the uart_to_tilelink side.
//  Sub-module tl_pkt_fifo: single-clock FIFO with WIDTH=8*PKT_BYTES and DEPTH parameters.
//   Provides push, pop, full, empty and count; async active-high reset.
//  Top holds the packer logic, the IDLE/SEND FSM, the shift register, byte_idx and the status logic.
// TESTING
//  T1 ADDR_BYTES=4: chanId=3, opcode=1, param=0, size=3, union=0,
//   addr=0x8000_1000, data=0x1122334455667788, tx_ready=1
//   -> 16 bytes 03 01 03 00 00 10 00 80 88 77 66 55 44 33 22 11. count=1.
//  T2 ADDR_BYTES=8, same frame with addr=0x1_8000_1000
//   -> 20 bytes; bytes 4..11 = 00 10 00 80 01 00 00 00. addr_trunc_err stays 0.
//  T3 ADDR_BYTES=4 with addr=0x1_0000_0000 and union=0x1FF
//   -> both flags set, byte 3=FF.
//   Then status_clear pulse -> flags 0, count 0.
//  T4 tx_ready=0, push 5 frames with FIFO_DEPTH=4
//   -> tl_out_ready low after 4 accepted plus 1 loaded to shreg (5th accepted).
//   Release tx_ready -> 5 packets in order, no bubble between packets.
//  T5 Random tx_ready stalls over 3 packets -> tx_data stable while tx_valid && !tx_ready.
//   Byte stream matches golden model.
//  T6 Assert reset after byte 7 of a packet -> outputs at reset values immediately.
//   After release, a new frame is sent from byte 0 and count=1.

Source files
------------

// File: rtl/tl_uart_pkg.sv
// Shared TileLink/UART packet definitions.
// Used by both the response packetizer and the uart_to_tilelink side.
package tl_uart_pkg;

    localparam logic [2:0] CH_A = 3'd0;
    localparam logic [2:0] CH_B = 3'd1;
    localparam logic [2:0] CH_C = 3'd2;
    localparam logic [2:0] CH_D = 3'd3;
    localparam logic [2:0] CH_E = 3'd4;

    localparam int CHAN_W   = 3;
    localparam int OPCODE_W = 3;
    localparam int PARAM_W  = 3;
    localparam int SIZE_W   = 8;
    localparam int SOURCE_W = 8;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int UNION_W  = 9;

    localparam int HDR_BYTES  = 4;
    localparam int DATA_BYTES = 8;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_e;

    function automatic int pkt_bytes(input int addr_bytes);
        return HDR_BYTES + DATA_BYTES + addr_bytes;
    endfunction

    function automatic logic [7:0] pack_opcode(
        input logic       corrupt,
        input logic [2:0] param,
        input logic [2:0] opcode
    );
        return {corrupt, param, 1'b0, opcode};
    endfunction

endpackage

// File: rtl/tl_pkt_fifo.sv
// Single-clock packet FIFO; head is readable combinationally.
// Pointers wrap naturally, count carries one extra bit for full.
module tl_pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

endmodule

// File: rtl/tl_response_packetizer.sv
// Packs TileLink frames into tl_host.py packets and streams
// them byte-by-byte toward uart_tx through a small packet FIFO.
module tl_response_packetizer
    import tl_uart_pkg::*;
#(
    parameter int ADDR_BYTES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tl_out_valid,
    output logic             tl_out_ready,
    input  logic [2:0]       tl_out_bits_chanId,
    input  logic [2:0]       tl_out_bits_opcode,
    input  logic [2:0]       tl_out_bits_param,
    input  logic [7:0]       tl_out_bits_size,
    input  logic [7:0]       tl_out_bits_source,
    input  logic [63:0]      tl_out_bits_address,
    input  logic [63:0]      tl_out_bits_data,
    input  logic             tl_out_bits_corrupt,
    input  logic [8:0]       tl_out_bits_union,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    input  logic             status_clear,
    output logic             addr_trunc_err,
    output logic             union_trunc_err,
    output logic [CNT_W-1:0] tx_pkt_count
);

    localparam int PKT_BYTES = pkt_bytes(ADDR_BYTES);
    localparam int PKT_W     = 8 * PKT_BYTES;
    localparam int IDX_W     = $clog2(PKT_BYTES);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

    logic [PKT_W-1:0] pkt;
    logic [PKT_W-1:0] head;
    logic [PKT_W-1:0] shreg;
    logic [PKT_W-1:0] shreg_d;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] byte_idx_d;
    logic [AW:0]      fifo_count;
    tx_state_e        state;
    tx_state_e        state_d;
    logic             accept;
    logic             full;
    logic             empty;
    logic             pop;
    logic             pkt_done;
    logic             addr_hi_nz;
    logic             unused_source;

    assign unused_source = ^tl_out_bits_source;

    // Byte 0 sits in the low bits so the shifter emits it first.
    assign pkt = {
        tl_out_bits_data,
        tl_out_bits_address[8*ADDR_BYTES-1:0],
        tl_out_bits_union[7:0],
        tl_out_bits_size,
        pack_opcode(tl_out_bits_corrupt,
                    tl_out_bits_param,
                    tl_out_bits_opcode),
        {5'b0, tl_out_bits_chanId}
    };

    generate
        if (ADDR_BYTES < 8) begin : g_trunc
            assign addr_hi_nz =
                |tl_out_bits_address[63:8*ADDR_BYTES];
        end else begin : g_notrunc
            assign addr_hi_nz = 1'b0;
        end
    endgenerate

    assign tl_out_ready =
        (fifo_count != (AW+1)'(FIFO_DEPTH));
    assign accept  = tl_out_valid && !full;
    assign tx_data = shreg[7:0];

    tl_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (pkt),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        byte_idx_d = byte_idx;
        pop        = 1'b0;
        pkt_done   = 1'b0;
        tx_valid   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shreg_d    = head;
                    byte_idx_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    shreg_d    = shreg >> 8;
                    byte_idx_d = byte_idx + 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        pkt_done   = 1'b1;
                        byte_idx_d = '0;
                        // Chain straight into the next packet.
                        if (!empty) begin
                            pop     = 1'b1;
                            shreg_d = head;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            byte_idx <= '0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            byte_idx <= byte_idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_trunc_err  <= 1'b0;
            union_trunc_err <= 1'b0;
            tx_pkt_count    <= '0;
        end else if (status_clear) begin
            addr_trunc_err  <= 1'b0;
            union_trunc_err <= 1'b0;
            tx_pkt_count    <= '0;
        end else begin
            if (accept && addr_hi_nz)
                addr_trunc_err <= 1'b1;
            if (accept && tl_out_bits_union[8])
                union_trunc_err <= 1'b1;
            if (pkt_done)
                tx_pkt_count <= tx_pkt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_tl_response_packetizer.sv
// Scoreboard bench for tl_response_packetizer with 4- and
// 8-byte address instances sharing the frame bus.
module tb_tl_response_packetizer;

    typedef struct packed {
        logic [2:0]  ch;
        logic [2:0]  op;
        logic [2:0]  param;
        logic [7:0]  size;
        logic [63:0] addr;
        logic [63:0] data;
        logic        corrupt;
        logic [8:0]  un;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        status_clear;
    logic [2:0]  b_ch, b_op, b_param;
    logic [7:0]  b_size, b_src;
    logic [63:0] b_addr, b_data;
    logic        b_corrupt;
    logic [8:0]  b_union;

    logic        v4, rdy4, txv4, txr4, at4, ut4;
    logic [7:0]  txd4;
    logic [15:0] cnt4;
    logic        v8, rdy8, txv8, txr8, at8, ut8;
    logic [7:0]  txd8;
    logic [15:0] cnt8;

    int tests = 0;
    int fails = 0;
    int exp_cnt4 = 0;

    logic [7:0] q4[$];
    logic [7:0] q8[$];
    int sent4 = 0;
    bit stall4 = 0;
    bit stall8 = 0;
    logic [7:0] hold4, hold8;

    always #5 clk = ~clk;

    tl_response_packetizer #(
        .ADDR_BYTES(4), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut4 (
        .clk(clk), .reset(reset),
        .tl_out_valid(v4), .tl_out_ready(rdy4),
        .tl_out_bits_chanId(b_ch),
        .tl_out_bits_opcode(b_op),
        .tl_out_bits_param(b_param),
        .tl_out_bits_size(b_size),
        .tl_out_bits_source(b_src),
        .tl_out_bits_address(b_addr),
        .tl_out_bits_data(b_data),
        .tl_out_bits_corrupt(b_corrupt),
        .tl_out_bits_union(b_union),
        .tx_valid(txv4), .tx_ready(txr4), .tx_data(txd4),
        .status_clear(status_clear),
        .addr_trunc_err(at4), .union_trunc_err(ut4),
        .tx_pkt_count(cnt4)
    );

    tl_response_packetizer #(
        .ADDR_BYTES(8), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut8 (
        .clk(clk), .reset(reset),
        .tl_out_valid(v8), .tl_out_ready(rdy8),
        .tl_out_bits_chanId(b_ch),
        .tl_out_bits_opcode(b_op),
        .tl_out_bits_param(b_param),
        .tl_out_bits_size(b_size),
        .tl_out_bits_source(b_src),
        .tl_out_bits_address(b_addr),
        .tl_out_bits_data(b_data),
        .tl_out_bits_corrupt(b_corrupt),
        .tl_out_bits_union(b_union),
        .tx_valid(txv8), .tx_ready(txr8), .tx_data(txd8),
        .status_clear(status_clear),
        .addr_trunc_err(at8), .union_trunc_err(ut8),
        .tx_pkt_count(cnt8)
    );

    function automatic logic [7:0] exp_byte(
        input int ab, input int i, input frame_t f);
        case (i)
            0: return {5'b0, f.ch};
            1: return {f.corrupt, f.param, 1'b0, f.op};
            2: return f.size;
            3: return f.un[7:0];
            default:
                if (i < 4 + ab) return f.addr[(i-4)*8 +: 8];
                else return f.data[(i-4-ab)*8 +: 8];
        endcase
    endfunction

    // Byte monitors: pop expected bytes on each handshake.
    always @(negedge clk) begin
        if (reset) begin
            stall4 = 0;
        end else begin
            if (stall4) begin
                tests++;
                if (txv4 !== 1'b1 || txd4 !== hold4) begin
                    fails++;
                    $display("FAIL stable4: valid=%b data=%02h required valid=1 data=%02h",
                             txv4, txd4, hold4);
                end
            end
            stall4 = 0;
            if (txv4 === 1'b1 && txr4 === 1'b1) begin
                tests++;
                sent4++;
                if (q4.size() == 0) begin
                    fails++;
                    $display("FAIL byte4: got %02h required no byte", txd4);
                end else begin
                    logic [7:0] e;
                    e = q4.pop_front();
                    if (txd4 !== e) begin
                        fails++;
                        $display("FAIL byte4: got %02h required %02h", txd4, e);
                    end
                end
            end else if (txv4 === 1'b1) begin
                stall4 = 1;
                hold4  = txd4;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall8 = 0;
        end else begin
            if (stall8) begin
                tests++;
                if (txv8 !== 1'b1 || txd8 !== hold8) begin
                    fails++;
                    $display("FAIL stable8: data=%02h required %02h", txd8, hold8);
                end
            end
            stall8 = 0;
            if (txv8 === 1'b1 && txr8 === 1'b1) begin
                tests++;
                if (q8.size() == 0) begin
                    fails++;
                    $display("FAIL byte8: got %02h required no byte", txd8);
                end else begin
                    logic [7:0] e;
                    e = q8.pop_front();
                    if (txd8 !== e) begin
                        fails++;
                        $display("FAIL byte8: got %02h required %02h", txd8, e);
                    end
                end
            end else if (txv8 === 1'b1) begin
                stall8 = 1;
                hold8  = txd8;
            end
        end
    end

    // Present a frame until accepted; expected bytes queued on accept.
    task automatic send(input bit to8, input frame_t f, output bit ok);
        int ab;
        ab = to8 ? 8 : 4;
        b_ch = f.ch; b_op = f.op; b_param = f.param;
        b_size = f.size; b_addr = f.addr; b_data = f.data;
        b_corrupt = f.corrupt; b_union = f.un;
        b_src = 8'($urandom);
        if (to8) v8 = 1'b1; else v4 = 1'b1;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if ((to8 ? rdy8 : rdy4) === 1'b1) begin
                ok = 1;
                for (int i = 0; i < 12 + ab; i++) begin
                    if (to8) q8.push_back(exp_byte(ab, i, f));
                    else     q4.push_back(exp_byte(ab, i, f));
                end
            end
            @(posedge clk); #1;
        end
        v4 = 1'b0;
        v8 = 1'b0;
    endtask

    task automatic wait_drain(input bit to8, output bit ok);
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk); #1;
            if (to8) ok = (q8.size() == 0) && (txv8 === 1'b0);
            else     ok = (q4.size() == 0) && (txv4 === 1'b0);
        end
    endtask

    function automatic frame_t base_frame(input logic [63:0] addr);
        frame_t f;
        f.ch = 3'd3; f.op = 3'd1; f.param = 3'd0; f.size = 8'd3;
        f.un = 9'h000; f.corrupt = 1'b0; f.addr = addr;
        f.data = 64'h1122334455667788;
        return f;
    endfunction

    task automatic test_reset();
        tests++;
        if (txv4 !== 1'b0 || rdy4 !== 1'b1 || txd4 !== 8'h00) begin
            fails++;
            $display("FAIL reset_io: valid=%b ready=%b data=%02h required 0 1 00",
                     txv4, rdy4, txd4);
        end
        tests++;
        if (cnt4 !== 16'd0 || at4 !== 1'b0 || ut4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: cnt=%0d at=%b ut=%b required 0 0 0",
                     cnt4, at4, ut4);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (txv4 !== 1'b0 || rdy4 !== 1'b1 || txv8 !== 1'b0 || rdy8 !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle: v4=%b r4=%b v8=%b r8=%b required 0 1 0 1",
                     txv4, rdy4, txv8, rdy8);
        end
    endtask

    task automatic test_basic4();
        bit ok;
        txr4 = 1'b1;
        send(0, base_frame(64'h8000_1000), ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL t1_accept: ok=0 required 1"); end
        tests++;
        if (txv4 !== 1'b0) begin
            fails++; $display("FAIL t1_latency1: tx_valid=%b required 0", txv4);
        end
        @(posedge clk); #1;
        tests++;
        if (txv4 !== 1'b1) begin
            fails++; $display("FAIL t1_latency2: tx_valid=%b required 1", txv4);
        end
        wait_drain(0, ok);
        exp_cnt4 = 1;
        tests++;
        if (!ok || cnt4 !== 16'(exp_cnt4) || at4 !== 1'b0 || ut4 !== 1'b0) begin
            fails++;
            $display("FAIL t1_done: drained=%b cnt=%0d at=%b ut=%b required 1 %0d 0 0",
                     ok, cnt4, at4, ut4, exp_cnt4);
        end
    endtask

    task automatic test_addr8();
        bit ok;
        send(1, base_frame(64'h1_8000_1000), ok);
        wait_drain(1, ok);
        tests++;
        if (!ok || cnt8 !== 16'd1 || at8 !== 1'b0 || ut8 !== 1'b0) begin
            fails++;
            $display("FAIL t2_done: drained=%b cnt=%0d at=%b ut=%b required 1 1 0 0",
                     ok, cnt8, at8, ut8);
        end
    endtask

    task automatic test_trunc_flags();
        bit ok;
        frame_t f;
        int base;
        f = base_frame(64'h1_0000_0000);
        f.un = 9'h1FF;
        send(0, f, ok);
        tests++;
        if (at4 !== 1'b1 || ut4 !== 1'b1) begin
            fails++;
            $display("FAIL t3_set: at=%b ut=%b required 1 1", at4, ut4);
        end
        wait_drain(0, ok);
        exp_cnt4++;
        tests++;
        if (!ok || cnt4 !== 16'(exp_cnt4)) begin
            fails++;
            $display("FAIL t3_cnt: cnt=%0d required %0d", cnt4, exp_cnt4);
        end
        status_clear = 1'b1;
        @(posedge clk); #1;
        status_clear = 1'b0;
        exp_cnt4 = 0;
        tests++;
        if (at4 !== 1'b0 || ut4 !== 1'b0 || cnt4 !== 16'd0) begin
            fails++;
            $display("FAIL t3_clear: at=%b ut=%b cnt=%0d required 0 0 0",
                     at4, ut4, cnt4);
        end
        // clear held across the accepting edge beats the flag set
        status_clear = 1'b1;
        send(0, f, ok);
        status_clear = 1'b0;
        tests++;
        if (at4 !== 1'b0 || ut4 !== 1'b0) begin
            fails++;
            $display("FAIL clear_vs_set: at=%b ut=%b required 0 0", at4, ut4);
        end
        // clear on the final byte handshake beats the increment
        base = sent4;
        for (int c = 0; c < 200 && sent4 != base + 15; c++) begin
            @(posedge clk); #1;
        end
        status_clear = 1'b1;
        @(posedge clk); #1;
        status_clear = 1'b0;
        wait_drain(0, ok);
        tests++;
        if (!ok || cnt4 !== 16'd0) begin
            fails++;
            $display("FAIL clear_vs_inc: cnt=%0d required 0", cnt4);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        frame_t f;
        int bubbles;
        txr4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            f = base_frame(64'h4000 + 64'(k));
            f.data = 64'hA0A0_0000_0000_0000 | 64'(k);
            f.ch = 3'(k);
            send(0, f, ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL t4_accept%0d: ok=0 required 1", k);
            end
        end
        tests++;
        if (rdy4 !== 1'b0) begin
            fails++; $display("FAIL t4_full: ready=%b required 0", rdy4);
        end
        b_data = 64'hDEAD;
        v4 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (rdy4 !== 1'b0) begin
                fails++; $display("FAIL t4_hold: ready=%b required 0", rdy4);
            end
            @(posedge clk); #1;
        end
        v4 = 1'b0;
        txr4 = 1'b1;
        bubbles = 0;
        repeat (80) begin
            @(negedge clk);
            if (txv4 !== 1'b1) bubbles++;
        end
        tests++;
        if (bubbles != 0) begin
            fails++; $display("FAIL t4_bubble: gaps=%0d required 0", bubbles);
        end
        @(posedge clk); #1;
        tests++;
        if (txv4 !== 1'b0 || q4.size() != 0) begin
            fails++;
            $display("FAIL t4_empty: valid=%b left=%0d required 0 0",
                     txv4, q4.size());
        end
        exp_cnt4 += 5;
        tests++;
        if (cnt4 !== 16'(exp_cnt4)) begin
            fails++; $display("FAIL t4_cnt: cnt=%0d required %0d", cnt4, exp_cnt4);
        end
    endtask

    task automatic test_random_stall();
        bit ok;
        frame_t f;
        bit ea, eu;
        ea = 0; eu = 0;
        txr4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            f.ch = 3'($urandom); f.op = 3'($urandom);
            f.param = 3'($urandom); f.size = 8'($urandom);
            f.addr = {$urandom(), $urandom()};
            f.data = {$urandom(), $urandom()};
            f.corrupt = 1'($urandom); f.un = 9'($urandom);
            if (f.addr[63:32] != 0) ea = 1;
            if (f.un[8]) eu = 1;
            send(0, f, ok);
        end
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk); #1;
            txr4 = 1'($urandom_range(0, 1));
            ok = (q4.size() == 0) && (txv4 === 1'b0);
        end
        txr4 = 1'b1;
        exp_cnt4 += 3;
        tests++;
        if (!ok || cnt4 !== 16'(exp_cnt4)) begin
            fails++;
            $display("FAIL t5_done: drained=%b cnt=%0d required 1 %0d",
                     ok, cnt4, exp_cnt4);
        end
        tests++;
        if (at4 !== ea || ut4 !== eu) begin
            fails++;
            $display("FAIL t5_flags: at=%b ut=%b required %b %b", at4, ut4, ea, eu);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        int base;
        frame_t f;
        f = base_frame(64'h2_0000_0010);
        f.un = 9'h100;
        txr4 = 1'b1;
        base = sent4;
        send(0, f, ok);
        for (int c = 0; c < 200 && sent4 != base + 8; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        tests++;
        if (txv4 !== 1'b0 || rdy4 !== 1'b1 || txd4 !== 8'h00 ||
            cnt4 !== 16'd0 || at4 !== 1'b0 || ut4 !== 1'b0) begin
            fails++;
            $display("FAIL t6_reset: v=%b r=%b d=%02h cnt=%0d at=%b ut=%b required 0 1 00 0 0 0",
                     txv4, rdy4, txd4, cnt4, at4, ut4);
        end
        q4.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send(0, base_frame(64'h0000_0ABC), ok);
        wait_drain(0, ok);
        tests++;
        if (!ok || cnt4 !== 16'd1) begin
            fails++;
            $display("FAIL t6_after: drained=%b cnt=%0d required 1 1", ok, cnt4);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        status_clear = 1'b0;
        v4 = 1'b0; v8 = 1'b0;
        txr4 = 1'b1; txr8 = 1'b1;
        b_ch = '0; b_op = '0; b_param = '0; b_size = '0;
        b_src = '0; b_addr = '0; b_data = '0;
        b_corrupt = 1'b0; b_union = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic4();
        test_addr8();
        test_trunc_flags();
        test_back_to_back();
        test_random_stall();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
